// File: rtl/mult_pkg.sv
// Shared definitions for the sequential Booth multiplier: FSM states,
// default operand widths and the step-counter width helper.
package mult_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int A_W_DEF = 11;
  localparam int B_W_DEF = 8;

  // The counter must be able to hold B_W itself, not just B_W-1.
  function automatic int cnt_w(input int b_w);
    return $clog2(b_w + 1);
  endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth step: conditional add/subtract of M into the accumulator,
// then an arithmetic right shift of {Acc, Q, q-1}.
module booth_step #(
  parameter int A_W = 11,
  parameter int B_W = 8
) (
  input  logic [A_W:0]   acc_i,
  input  logic [B_W-1:0] q_i,
  input  logic           qm1_i,
  input  logic [A_W:0]   m_i,
  output logic [A_W:0]   acc_o,
  output logic [B_W-1:0] q_o,
  output logic           qm1_o
);

  logic [A_W:0] sum;

  always_comb begin
    sum = acc_i;
    case ({q_i[0], qm1_i})
      2'b01:   sum = acc_i + m_i;
      2'b10:   sum = acc_i - m_i;
      default: sum = acc_i;
    endcase
  end

  assign acc_o = {sum[A_W], sum[A_W:1]};
  assign q_o   = {sum[0], q_i[B_W-1:1]};
  assign qm1_o = q_i[0];

endmodule

// File: rtl/mult_booth_seq.sv
// Sequential signed x signed radix-2 Booth multiplier, one step per clock.
// Optional MULT_ZERO_SKIP_EN: zero operands complete in one cycle without RUN.
module mult_booth_seq
  import mult_pkg::*;
#(
  parameter int A_W = A_W_DEF,
  parameter int B_W = B_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [A_W-1:0]     n1,
  input  logic [B_W-1:0]     n2,
  output logic               busy,
  output logic               done,
  output logic [A_W+B_W-1:0] result
);

  localparam int CW  = cnt_w(B_W);
  localparam int P_W = A_W + B_W;

  state_e           state_q, state_d;
  logic [A_W:0]     m_q, m_d;
  logic [A_W:0]     acc_q, acc_d;
  logic [B_W-1:0]   q_q, q_d;
  logic             qm1_q, qm1_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [P_W-1:0]   result_q, result_d;

  logic [A_W:0]     acc_s;
  logic [B_W-1:0]   q_s;
  logic             qm1_s;
  logic [P_W:0]     prod_s;
  logic             skip;
  logic             last_step;

  booth_step #(.A_W(A_W), .B_W(B_W)) u_step (
    .acc_i (acc_q),
    .q_i   (q_q),
    .qm1_i (qm1_q),
    .m_i   (m_q),
    .acc_o (acc_s),
    .q_o   (q_s),
    .qm1_o (qm1_s)
  );

`ifdef MULT_ZERO_SKIP_EN
  assign skip = (n1 == '0) || (n2 == '0);
`else
  assign skip = 1'b0;
`endif

  assign last_step = (cnt_q == CW'(B_W - 1));
  // Acc carries one guard bit; the product is the low P_W bits of {Acc, Q}.
  assign prod_s    = {acc_s, q_s};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      m_q      <= '0;
      acc_q    <= '0;
      q_q      <= '0;
      qm1_q    <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      m_q      <= m_d;
      acc_q    <= acc_d;
      q_q      <= q_d;
      qm1_q    <= qm1_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && !skip) state_d = RUN;
      RUN:     if (last_step) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m_d      = m_q;
    acc_d    = acc_q;
    q_d      = q_q;
    qm1_d    = qm1_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (skip) begin
            result_d = '0;
            done_d   = 1'b1;
          end else begin
            m_d    = {n1[A_W-1], n1};
            acc_d  = '0;
            q_d    = n2;
            qm1_d  = 1'b0;
            cnt_d  = '0;
            busy_d = 1'b1;
          end
        end
      end
      RUN: begin
        acc_d = acc_s;
        q_d   = q_s;
        qm1_d = qm1_s;
        cnt_d = CW'(cnt_q + 1'b1);
        if (last_step) begin
          result_d = prod_s[P_W-1:0];
          done_d   = 1'b1;
          busy_d   = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_mult_booth_seq.sv
// Directed-vector bench for mult_booth_seq at default widths (11 x 8).
// Zero-operand expectations follow MULT_ZERO_SKIP_EN when it is defined.
module tb_mult_booth_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [10:0] n1;
  logic [7:0]  n2;
  logic        busy;
  logic        done;
  logic [18:0] result;

  int n_checks = 0;
  int n_errors = 0;

  mult_booth_seq dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .n1     (n1),
    .n2     (n2),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge. Issues one operation, tracks the done edge index
  // (0 = first negedge after the accepting edge) and the busy cycle count.
  // Returns at the negedge of the done cycle with start low.
  task automatic do_op(input logic [10:0] a, input logic [7:0] b,
                       input logic [18:0] exp, input int exp_lat,
                       input bit glitch, input string tag);
    int  lat;
    int  busy_cnt;
    bit  seen;
    start = 1'b1;
    n1    = a;
    n2    = b;
    @(posedge clk);
    #1;
    start    = 1'b0;
    n1       = 11'($urandom);
    n2       = 8'($urandom);
    busy_cnt = 0;
    seen     = 1'b0;
    lat      = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        seen = 1'b1;
        lat  = i;
        break;
      end
      start = (glitch && (i == 3 || i == 5)) ? 1'b1 : 1'b0;
    end
    start = 1'b0;
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_result"}, 32'(result), 32'(exp));
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_lat));
    $display("op %s: n1=0x%03h n2=0x%02h result=0x%05h latency=%0d", tag, a, b, result, lat);
  endtask

  initial begin
    int busy_seen;
    int done_seen;
    start = 1'b0;
    n1    = '0;
    n2    = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    busy_seen = 0;
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) busy_seen++;
      if (done) done_seen++;
    end
    check("idle_busy_cycles", 32'(busy_seen), 32'd0);
    check("idle_done_cycles", 32'(done_seen), 32'd0);
    check("idle_result", 32'(result), 32'd0);
    $display("idle: busy=%0b done=%0b result=0x%05h", busy, done, result);

    do_op(11'h555, 8'h55, 19'h71D39, 8, 1'b0, "basic");

    // Back-to-back corners: each do_op returns in the done cycle, so the
    // next start lands while done is high.
    do_op(11'h7FF, 8'h80, 19'h00080, 8, 1'b0, "m1_x_min");
    do_op(11'h400, 8'h80, 19'h20000, 8, 1'b0, "min_x_min");
    do_op(11'h3FF, 8'h7F, 19'h1FB81, 8, 1'b0, "max_x_max");
    do_op(11'h555, 8'hFF, 19'h002AB, 8, 1'b0, "neg_x_m1");
    @(negedge clk);
    check("done_pulse_width", 32'(done), 32'd0);
    check("result_hold", 32'(result), 32'h002AB);

    do_op(11'h0C3, 8'hF6, 19'h7F862, 8, 1'b1, "start_ignored");
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("start_ignored_no_extra_done", 32'(done_seen), 32'd0);

    // Abort mid-run with an asynchronous reset between clock edges.
    start = 1'b1;
    n1    = 11'h123;
    n2    = 8'h45;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_result", 32'(result), 32'd0);
    $display("abort: busy=%0b done=%0b result=0x%05h", busy, done, result);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("abort_no_done", 32'(done_seen), 32'd0);

    do_op(11'h123, 8'h45, 19'h04E6F, 8, 1'b0, "after_abort");

`ifdef MULT_ZERO_SKIP_EN
    do_op(11'h7FF, 8'h00, 19'h00000, 0, 1'b0, "zero_skip");
`else
    do_op(11'h7FF, 8'h00, 19'h00000, 8, 1'b0, "zero_full");
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
